// File: rtl/bp_pkg.sv
`default_nettype none
// =============================================================================
// Module      : bp_pkg
// Description : Branch predictor counter states and the saturating-update rule.
// Revision    : 1.0 - initial release
// =============================================================================
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET_STATE = WNT;

    function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
        bht_state_t nxt;
        nxt = cur;
        if (taken && (cur != ST)) begin
            nxt = bht_state_t'(cur + 2'd1);
        end else if (!taken && (cur != SNT)) begin
            nxt = bht_state_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_hazard_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module      : branch_hazard_ctrl_if
// Description : Pipeline-side signal bundle of the branch/hazard control unit.
// Revision    : 1.0 - initial release
// =============================================================================
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      id_pc_i;
    logic             id_branch_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_uses_rs2_i;
    logic [31:0]      ex_pc_i;
    logic             ex_branch_i;
    logic             ex_taken_i;
    logic             ex_predict_taken_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rd_i;
    logic             predict_taken_o;
    logic             pred_redirect_o;
    logic             stall_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             mispredict_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    modport master (
        output id_pc_i, id_branch_i, id_rs1_i, id_rs2_i, id_uses_rs2_i,
        output ex_pc_i, ex_branch_i, ex_taken_i, ex_predict_taken_i, ex_memread_i, ex_rd_i,
        input  predict_taken_o, pred_redirect_o, stall_o, if_id_flush_o, id_ex_flush_o,
        input  mispredict_o, branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  id_pc_i, id_branch_i, id_rs1_i, id_rs2_i, id_uses_rs2_i,
        input  ex_pc_i, ex_branch_i, ex_taken_i, ex_predict_taken_i, ex_memread_i, ex_rd_i,
        output predict_taken_o, pred_redirect_o, stall_o, if_id_flush_o, id_ex_flush_o,
        output mispredict_o, branch_cnt_o, mispredict_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_hist_table.sv
`default_nettype none
// =============================================================================
// Module      : branch_hist_table
// Description : Table of 2-bit saturating counters, one async read, one update.
// Revision    : 1.0 - initial release
// =============================================================================
module branch_hist_table
    import bp_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic [IDX_W-1:0] rd_idx,
    output bht_state_t            rd_state,
    input  wire logic             upd_en,
    input  wire logic [IDX_W-1:0] upd_idx,
    input  wire logic             upd_taken
);

    bht_state_t r_bht [BHT_ENTRIES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= BHT_RESET_STATE;
            end
        end else if (upd_en) begin
            r_bht[upd_idx] <= bht_next(r_bht[upd_idx], upd_taken);
        end
    end

    // Read sees the pre-update value when it collides with an update.
    assign rd_state = r_bht[rd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : branch_hazard_ctrl
// Description : Branch prediction, load-use/mispredict hazard control, perf counters.
// Revision    : 1.0 - initial release
// =============================================================================
module branch_hazard_ctrl
    import bp_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES),
    parameter int CNT_W       = 16
) (
    input wire logic      clk_i,
    input wire logic      rst_i,
    branch_hazard_ctrl_if.slave bus
);

    bht_state_t       w_rd_state;
    logic             w_mispredict;
    logic             w_load_use;
    logic             w_predict;
    logic             w_redirect;
    logic             w_stall;
    logic             w_if_id_flush;
    logic             w_id_ex_flush;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;
    logic             w_unused_pc;

    assign w_unused_pc = ^{bus.id_pc_i[31:IDX_W+2], bus.id_pc_i[1:0],
                           bus.ex_pc_i[31:IDX_W+2], bus.ex_pc_i[1:0]};

    branch_hist_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_bht (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx    (bus.id_pc_i[IDX_W+1:2]),
        .rd_state  (w_rd_state),
        .upd_en    (bus.ex_branch_i),
        .upd_idx   (bus.ex_pc_i[IDX_W+1:2]),
        .upd_taken (bus.ex_taken_i)
    );

    assign w_mispredict = bus.ex_branch_i & (bus.ex_taken_i != bus.ex_predict_taken_i);
    assign w_load_use   = bus.ex_memread_i & (bus.ex_rd_i != 5'd0) &
                          ((bus.ex_rd_i == bus.id_rs1_i) |
                           (bus.id_uses_rs2_i & (bus.ex_rd_i == bus.id_rs2_i)));

    // A mispredict squashes the ID instruction, so it also overrides load-use.
    always_comb begin
        w_predict     = 1'b0;
        w_redirect    = 1'b0;
        w_stall       = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        if (w_mispredict) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_stall       = 1'b1;
            w_id_ex_flush = 1'b1;
        end else begin
            w_predict     = bus.id_branch_i & w_rd_state[1];
            w_redirect    = w_predict;
            w_if_id_flush = w_predict;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (bus.ex_branch_i) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.predict_taken_o  = w_predict;
    assign bus.pred_redirect_o  = w_redirect;
    assign bus.stall_o          = w_stall;
    assign bus.if_id_flush_o    = w_if_id_flush;
    assign bus.id_ex_flush_o    = w_id_ex_flush;
    assign bus.mispredict_o     = w_mispredict;
    assign bus.branch_cnt_o     = r_branch_cnt;
    assign bus.mispredict_cnt_o = r_mispredict_cnt;

endmodule
`default_nettype wire
